// File: rtl/iobus_sseg_scan_ctrl.sv
// OTTER I/O-bus seven-segment scan controller: firmware writes a 16-bit hex value
// and a control word; the block multiplexes the four Basys3 digits in hardware.
module iobus_sseg_scan_ctrl #(
   parameter logic [31:0] VALUE_ADDR  = 32'h1100C010,
   parameter logic [31:0] CTRL_ADDR   = 32'h1100C014,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] iobus_addr,
   input  logic [31:0] iobus_out,
   input  logic        iobus_wr,
   output logic [31:0] rd_data,
   output logic        rd_hit,
   output logic [7:0]  seg,
   output logic [3:0]  an
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [15:0]      r_value;
   logic             r_en;
   logic             r_lzb;
   logic [3:0]       r_dp;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;

   logic             value_hit;
   logic             ctrl_hit;
   logic             cnt_last;
   logic [3:0]       cur_nib;
   logic [3:0]       lz_blank;
   logic [3:0]       an_nxt;
   logic [7:0]       seg_nxt;
   logic             unused_bits;

   function automatic logic [6:0] seg_font(input logic [3:0] nib);
      logic [6:0] f;
      case (nib)
         4'h0: f = 7'h40;
         4'h1: f = 7'h79;
         4'h2: f = 7'h24;
         4'h3: f = 7'h30;
         4'h4: f = 7'h19;
         4'h5: f = 7'h12;
         4'h6: f = 7'h02;
         4'h7: f = 7'h78;
         4'h8: f = 7'h00;
         4'h9: f = 7'h10;
         4'hA: f = 7'h08;
         4'hB: f = 7'h03;
         4'hC: f = 7'h46;
         4'hD: f = 7'h21;
         4'hE: f = 7'h06;
         default: f = 7'h0E;
      endcase
      return f;
   endfunction

   assign value_hit = (iobus_addr == VALUE_ADDR);
   assign ctrl_hit  = (iobus_addr == CTRL_ADDR);
   assign cnt_last  = (cnt == CNT_LAST);

   // Reserved bus bits are intentionally dropped.
   assign unused_bits = ^{iobus_out[31:16], iobus_out[3:2]};

   always_comb begin
      cur_nib = r_value[3:0];
      case (idx)
         2'd0: cur_nib = r_value[3:0];
         2'd1: cur_nib = r_value[7:4];
         2'd2: cur_nib = r_value[11:8];
         default: cur_nib = r_value[15:12];
      endcase
   end

   // A digit is a leading zero only if it and every digit to its left are zero.
   always_comb begin
      lz_blank    = 4'b0000;
      lz_blank[3] = r_lzb && (r_value[15:12] == 4'h0);
      lz_blank[2] = lz_blank[3] && (r_value[11:8] == 4'h0);
      lz_blank[1] = lz_blank[2] && (r_value[7:4] == 4'h0);
      lz_blank[0] = 1'b0;
   end

   // The terminal count cycle is forced dark so the outgoing digit never
   // bleeds into the incoming anode.
   always_comb begin
      an_nxt  = 4'hF;
      seg_nxt = 8'hFF;
      if (r_en && !cnt_last && !lz_blank[idx]) begin
         an_nxt  = ~(4'b0001 << idx);
         seg_nxt = {~r_dp[idx], seg_font(cur_nib)};
      end
   end

   always_comb begin
      rd_data = 32'h0;
      rd_hit  = 1'b0;
      if (value_hit) begin
         rd_data = {16'h0, r_value};
         rd_hit  = 1'b1;
      end else if (ctrl_hit) begin
         rd_data = {22'h0, idx, r_dp, 2'b00, r_lzb, r_en};
         rd_hit  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_value <= 16'h0;
         r_en    <= 1'b1;
         r_lzb   <= 1'b0;
         r_dp    <= 4'h0;
         cnt     <= '0;
         idx     <= 2'd0;
         an      <= 4'hF;
         seg     <= 8'hFF;
      end else begin
         if (iobus_wr && value_hit) begin
            r_value <= iobus_out[15:0];
         end
         if (iobus_wr && ctrl_hit) begin
            r_en  <= iobus_out[0];
            r_lzb <= iobus_out[1];
            r_dp  <= iobus_out[7:4];
         end
         if (!r_en) begin
            cnt <= '0;
            idx <= 2'd0;
         end else if (cnt_last) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end

endmodule
